// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter that serialises single-word read/write
// requests from two clients onto the shared memory's write and read ports,
// returning a one-cycle response (with timeout error) to the granted client.
module mem_arbiter #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 16
) (
  input  logic                    axis_aclk,
  input  logic                    axis_areset,

  input  logic                    req0_valid,
  input  logic                    req0_wr,
  input  logic [ADDR_WIDTH-1:0]   req0_addr,
  input  logic [DATA_WIDTH-1:0]   req0_wdata,
  input  logic [DATA_WIDTH/8-1:0] req0_tstrb,
  output logic                    req0_ready,

  input  logic                    req1_valid,
  input  logic                    req1_wr,
  input  logic [ADDR_WIDTH-1:0]   req1_addr,
  input  logic [DATA_WIDTH-1:0]   req1_wdata,
  input  logic [DATA_WIDTH/8-1:0] req1_tstrb,
  output logic                    req1_ready,

  output logic                    rsp0_valid,
  output logic [DATA_WIDTH-1:0]   rsp0_rdata,
  output logic                    rsp0_err,
  output logic                    rsp1_valid,
  output logic [DATA_WIDTH-1:0]   rsp1_rdata,
  output logic                    rsp1_err,

  output logic                    s02_axis_wr_en,
  output logic                    s02_axis_tvalid,
  output logic                    s02_axis_tlast,
  output logic [ADDR_WIDTH-1:0]   s02_axis_wr_addr,
  output logic [DATA_WIDTH-1:0]   s02_axis_wr_tdata,
  output logic [DATA_WIDTH/8-1:0] s02_axis_tstrb,
  input  logic                    s02_axis_tready,

  output logic                    m02_axis_rd_en,
  output logic                    m02_axis_tready,
  output logic [ADDR_WIDTH-1:0]   m02_axis_rd_addr,
  input  logic [DATA_WIDTH-1:0]   m02_axis_rd_tdata,
  input  logic                    m02_axis_tvalid
);

  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int CNT_W  = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t state, state_nxt;

  // Latched transaction; the WRITE/READ state itself records the direction.
  logic                  lat_id;
  logic [ADDR_WIDTH-1:0] lat_addr;
  logic [DATA_WIDTH-1:0] lat_wdata;
  logic [STRB_W-1:0]     lat_strb;
  logic [CNT_W-1:0]      cnt;
  logic                  last_grant;

  logic [DATA_WIDTH-1:0] rsp0_rdata_q, rsp1_rdata_q;
  logic                  rsp0_err_q, rsp1_err_q;

  // Grant decision and completion strobes
  logic                  grant_vld;
  logic                  grant_id;
  logic                  grant_wr;
  logic                  accept;
  logic                  finish;
  logic                  finish_err;
  logic [DATA_WIDTH-1:0] finish_rdata;

  // Tie goes to the requester that was not served last.
  function automatic logic pick_winner(input logic v0, input logic v1, input logic last);
    if (v0 && v1) return ~last;
    return v1;
  endfunction

  assign grant_vld = req0_valid | req1_valid;
  assign grant_id  = pick_winner(req0_valid, req1_valid, last_grant);
  assign grant_wr  = grant_id ? req1_wr : req0_wr;

  // Next-state decode plus Moore memory controls and handshake outputs
  always_comb begin
    state_nxt       = state;
    accept          = 1'b0;
    finish          = 1'b0;
    finish_err      = 1'b0;
    finish_rdata    = '0;
    req0_ready      = 1'b0;
    req1_ready      = 1'b0;
    rsp0_valid      = 1'b0;
    rsp1_valid      = 1'b0;
    s02_axis_wr_en  = 1'b0;
    s02_axis_tvalid = 1'b0;
    s02_axis_tlast  = 1'b0;
    m02_axis_rd_en  = 1'b0;
    m02_axis_tready = 1'b0;
    case (state)
      IDLE: begin
        if (grant_vld) begin
          accept     = 1'b1;
          req0_ready = ~grant_id;
          req1_ready = grant_id;
          state_nxt  = grant_wr ? WRITE : READ;
        end
      end
      WRITE: begin
        s02_axis_wr_en  = 1'b1;
        s02_axis_tvalid = 1'b1;
        s02_axis_tlast  = 1'b1;
        if (s02_axis_tready) begin
          finish    = 1'b1;
          state_nxt = RESP;
        end else if (cnt == CNT_LAST) begin
          finish     = 1'b1;
          finish_err = 1'b1;
          state_nxt  = RESP;
        end
      end
      READ: begin
        m02_axis_rd_en  = 1'b1;
        m02_axis_tready = 1'b1;
        if (m02_axis_tvalid) begin
          finish       = 1'b1;
          finish_rdata = m02_axis_rd_tdata;
          state_nxt    = RESP;
        end else if (cnt == CNT_LAST) begin
          finish     = 1'b1;
          finish_err = 1'b1;
          state_nxt  = RESP;
        end
      end
      RESP: begin
        rsp0_valid = ~lat_id;
        rsp1_valid = lat_id;
        state_nxt  = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge axis_aclk) begin
    if (axis_areset) state <= IDLE;
    else             state <= state_nxt;
  end

  // Request latch, timeout counter, round-robin pointer and response holding registers
  always_ff @(posedge axis_aclk) begin
    if (axis_areset) begin
      lat_id       <= 1'b0;
      lat_addr     <= '0;
      lat_wdata    <= '0;
      lat_strb     <= '0;
      cnt          <= '0;
      last_grant   <= 1'b1;
      rsp0_rdata_q <= '0;
      rsp0_err_q   <= 1'b0;
      rsp1_rdata_q <= '0;
      rsp1_err_q   <= 1'b0;
    end else begin
      if (accept) begin
        lat_id    <= grant_id;
        lat_addr  <= grant_id ? req1_addr  : req0_addr;
        lat_wdata <= grant_id ? req1_wdata : req0_wdata;
        lat_strb  <= grant_id ? req1_tstrb : req0_tstrb;
        cnt       <= '0;
      end else if (state == WRITE || state == READ) begin
        cnt <= cnt + 1'b1;
      end
      if (finish) begin
        if (lat_id) begin
          rsp1_rdata_q <= finish_rdata;
          rsp1_err_q   <= finish_err;
        end else begin
          rsp0_rdata_q <= finish_rdata;
          rsp0_err_q   <= finish_err;
        end
      end
      if (state == RESP) last_grant <= lat_id;
    end
  end

  assign rsp0_rdata        = rsp0_rdata_q;
  assign rsp0_err          = rsp0_err_q;
  assign rsp1_rdata        = rsp1_rdata_q;
  assign rsp1_err          = rsp1_err_q;
  assign s02_axis_wr_addr  = lat_addr;
  assign s02_axis_wr_tdata = lat_wdata;
  assign s02_axis_tstrb    = lat_strb;
  assign m02_axis_rd_addr  = lat_addr;

endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter: directed scenarios followed by randomized
// transactions, checked against a transaction-level model with a word memory.
module tb_mem_arbiter;

  localparam int AW = 12;
  localparam int DW = 32;
  localparam int SW = DW / 8;
  localparam int TO = 16;

  logic          axis_aclk = 1'b0;
  logic          axis_areset;
  logic          req0_valid, req0_wr, req0_ready;
  logic [AW-1:0] req0_addr;
  logic [DW-1:0] req0_wdata;
  logic [SW-1:0] req0_tstrb;
  logic          req1_valid, req1_wr, req1_ready;
  logic [AW-1:0] req1_addr;
  logic [DW-1:0] req1_wdata;
  logic [SW-1:0] req1_tstrb;
  logic          rsp0_valid, rsp0_err, rsp1_valid, rsp1_err;
  logic [DW-1:0] rsp0_rdata, rsp1_rdata;
  logic          s02_axis_wr_en, s02_axis_tvalid, s02_axis_tlast, s02_axis_tready;
  logic [AW-1:0] s02_axis_wr_addr;
  logic [DW-1:0] s02_axis_wr_tdata;
  logic [SW-1:0] s02_axis_tstrb;
  logic          m02_axis_rd_en, m02_axis_tready, m02_axis_tvalid;
  logic [AW-1:0] m02_axis_rd_addr;
  logic [DW-1:0] m02_axis_rd_tdata;

  mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
    .axis_aclk(axis_aclk), .axis_areset(axis_areset),
    .req0_valid(req0_valid), .req0_wr(req0_wr), .req0_addr(req0_addr),
    .req0_wdata(req0_wdata), .req0_tstrb(req0_tstrb), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_wr(req1_wr), .req1_addr(req1_addr),
    .req1_wdata(req1_wdata), .req1_tstrb(req1_tstrb), .req1_ready(req1_ready),
    .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata), .rsp0_err(rsp0_err),
    .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata), .rsp1_err(rsp1_err),
    .s02_axis_wr_en(s02_axis_wr_en), .s02_axis_tvalid(s02_axis_tvalid),
    .s02_axis_tlast(s02_axis_tlast), .s02_axis_wr_addr(s02_axis_wr_addr),
    .s02_axis_wr_tdata(s02_axis_wr_tdata), .s02_axis_tstrb(s02_axis_tstrb),
    .s02_axis_tready(s02_axis_tready),
    .m02_axis_rd_en(m02_axis_rd_en), .m02_axis_tready(m02_axis_tready),
    .m02_axis_rd_addr(m02_axis_rd_addr), .m02_axis_rd_tdata(m02_axis_rd_tdata),
    .m02_axis_tvalid(m02_axis_tvalid)
  );

  always #5 axis_aclk = ~axis_aclk;

  int checks = 0;
  int errors = 0;

  // Reference model state: memory contents, last served client, held responses
  logic [DW-1:0] mem_model [0:4095];
  int            last_win;
  logic [DW-1:0] hold_rdata [2];
  logic          hold_err [2];
  int            obs_win;

  task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge axis_aclk);
    #1;
  endtask

  function automatic logic [159:0] all_outs();
    return {req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp0_err, rsp1_err,
            rsp0_rdata, rsp1_rdata, s02_axis_wr_en, s02_axis_tvalid, s02_axis_tlast,
            s02_axis_wr_addr, s02_axis_wr_tdata, s02_axis_tstrb,
            m02_axis_rd_en, m02_axis_tready, m02_axis_rd_addr};
  endfunction

  function automatic int pick(input bit v0, input bit v1, input int last);
    if (v0 && v1) return 1 - last;
    return v1 ? 1 : 0;
  endfunction

  task automatic set_req(input int id, input bit wr, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input logic [SW-1:0] s);
    if (id == 0) begin
      req0_wr = wr; req0_addr = a; req0_wdata = d; req0_tstrb = s;
    end else begin
      req1_wr = wr; req1_addr = a; req1_wdata = d; req1_tstrb = s;
    end
  endtask

  // One complete transaction: accept, access phase with memory stall, response, hold.
  task automatic txn(input bit v0, input bit v1, input int stall);
    int            w, n;
    bit            wwr, ee;
    logic [AW-1:0] wa;
    logic [DW-1:0] wd, er;
    logic [SW-1:0] ws;
    w = pick(v0, v1, last_win);
    req0_valid = v0;
    req1_valid = v1;
    #1;
    chk("accept_ready", {req0_ready, req1_ready}, {w == 0, w == 1});
    obs_win = req1_ready ? 1 : (req0_ready ? 0 : -1);
    wwr = (w == 1) ? req1_wr    : req0_wr;
    wa  = (w == 1) ? req1_addr  : req0_addr;
    wd  = (w == 1) ? req1_wdata : req0_wdata;
    ws  = (w == 1) ? req1_tstrb : req0_tstrb;
    tick();
    n = (stall < TO - 1) ? stall : TO - 1;
    for (int k = 0; k <= n; k++) begin
      s02_axis_tready   = wwr && (k == stall);
      m02_axis_tvalid   = !wwr && (k == stall);
      m02_axis_rd_tdata = (k == stall) ? mem_model[wa] : DW'($urandom);
      #1;
      chk("access_ctl",
          {s02_axis_wr_en, s02_axis_tvalid, s02_axis_tlast, m02_axis_rd_en, m02_axis_tready,
           req0_ready, req1_ready, rsp0_valid, rsp1_valid},
          {wwr, wwr, wwr, !wwr, !wwr, 4'b0000});
      if (wwr) chk("wr_bus", {s02_axis_wr_addr, s02_axis_wr_tdata, s02_axis_tstrb}, {wa, wd, ws});
      else     chk("rd_addr", m02_axis_rd_addr, wa);
      tick();
      s02_axis_tready = 1'b0;
      m02_axis_tvalid = 1'b0;
    end
    #1;
    ee = (stall >= TO);
    er = (ee || wwr) ? '0 : mem_model[wa];
    chk("rsp_valid", {rsp0_valid, rsp1_valid}, {w == 0, w == 1});
    if (w == 0) chk("rsp0_payload", {rsp0_err, rsp0_rdata}, {ee, er});
    else        chk("rsp1_payload", {rsp1_err, rsp1_rdata}, {ee, er});
    chk("resp_quiet", {s02_axis_wr_en, m02_axis_rd_en, req0_ready, req1_ready}, 4'b0000);
    last_win      = w;
    hold_rdata[w] = er;
    hold_err[w]   = ee;
    if (wwr && !ee)
      for (int b = 0; b < SW; b++)
        if (ws[b]) mem_model[wa][8*b +: 8] = wd[8*b +: 8];
    tick();
    chk("rsp_hold", {rsp0_valid, rsp1_valid, rsp0_err, rsp0_rdata, rsp1_err, rsp1_rdata},
        {2'b00, hold_err[0], hold_rdata[0], hold_err[1], hold_rdata[1]});
  endtask

  initial begin
    logic [3:0] seq;
    int         r, st;
    for (int i = 0; i < 4096; i++) mem_model[i] = '0;
    last_win = 1;
    hold_rdata[0] = '0; hold_rdata[1] = '0;
    hold_err[0] = 1'b0; hold_err[1] = 1'b0;
    axis_areset = 1'b1;
    req0_valid = 0; req1_valid = 0;
    set_req(0, 0, '0, '0, '0);
    set_req(1, 0, '0, '0, '0);
    s02_axis_tready = 0; m02_axis_tvalid = 0; m02_axis_rd_tdata = '0;

    // Reset held two cycles, then ten quiet cycles
    tick(); tick();
    chk("reset_outputs", all_outs(), '0);
    axis_areset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("idle_quiet", all_outs(), '0);
    end

    // req0 write 0x22 to 0x001, no stall
    set_req(0, 1, 12'h001, 32'h0000_0022, 4'hF);
    txn(1, 0, 0);
    req0_valid = 0;
    // req1 read 0x001 with 3-cycle stall
    set_req(1, 0, 12'h001, '0, '0);
    txn(0, 1, 3);
    req1_valid = 0;
    chk("read_back", rsp1_rdata, 32'h0000_0022);

    // Both continuously valid: grants alternate starting with req0
    set_req(0, 0, 12'h010, '0, '0);
    set_req(1, 1, 12'h020, 32'hA5A5_5A5A, 4'b1010);
    for (int i = 0; i < 4; i++) begin
      txn(1, 1, i);
      seq[i] = obs_win[0];
    end
    chk("alternation", seq, 4'b1010);
    req0_valid = 0; req1_valid = 0;
    tick();

    // Read timeout, completion on the last allowed cycle, write timeout
    set_req(0, 0, 12'h030, '0, '0);
    txn(1, 0, 1000);
    req0_valid = 0;
    set_req(1, 0, 12'h020, '0, '0);
    txn(0, 1, TO - 1);
    req1_valid = 0;
    set_req(0, 1, 12'h040, 32'hDEAD_BEEF, 4'hF);
    txn(1, 0, TO + 3);
    req0_valid = 0;

    // Reset during a stalled read by req1 (last served was req0)
    set_req(1, 0, 12'h055, '0, '0);
    req1_valid = 1;
    #1;
    chk("rst_case_ready", {req0_ready, req1_ready}, 2'b01);
    tick();
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("stall_rd_en", {m02_axis_rd_en, m02_axis_rd_addr}, {1'b1, 12'h055});
      tick();
    end
    axis_areset = 1'b1;
    tick();
    axis_areset = 1'b0;
    req1_valid = 0;
    #1;
    chk("rst_abort_outputs", all_outs(), '0);
    last_win = 1;
    hold_rdata[0] = '0; hold_rdata[1] = '0;
    hold_err[0] = 1'b0; hold_err[1] = 1'b0;
    tick();
    chk("rst_no_rsp", all_outs(), '0);
    set_req(0, 0, 12'h001, '0, '0);
    set_req(1, 0, 12'h002, '0, '0);
    txn(1, 1, 0);
    chk("post_rst_tie_req0", obs_win, 0);
    req0_valid = 0; req1_valid = 0;

    // Randomized transactions over a small address window
    for (int i = 0; i < 40; i++) begin
      r = $urandom_range(1, 3);
      set_req(0, 1'($urandom), AW'($urandom_range(0, 15)), DW'($urandom), SW'($urandom));
      set_req(1, 1'($urandom), AW'($urandom_range(0, 15)), DW'($urandom), SW'($urandom));
      st = $urandom_range(0, 9);
      if (st == 7)      st = TO - 1;
      else if (st == 8) st = TO;
      else if (st == 9) st = TO + 5;
      txn(r[0], r[1], st);
      if ($urandom_range(0, 1) == 1) begin
        req0_valid = 0; req1_valid = 0;
        #1;
        chk("rand_idle_ready", {req0_ready, req1_ready}, 2'b00);
        tick();
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-requester arbiter and sequencer for the shared 4K x 32 `memory` block. It accepts single-word read/write requests from two client channels and grants them round-robin. It drives the memory's `s02_axis` write port and `m02_axis` read port one transaction at a time, then returns a one-cycle response, with a timeout error, to the granted client.

## Interface
Parameters:
- `ADDR_WIDTH`, 12, memory word-address width
- `DATA_WIDTH`, 32, data width; strobe width is `DATA_WIDTH/8`
- `TIMEOUT`, 16, cycles allowed in WRITE/READ before error (≥2)

Ports:
- `axis_aclk`  in  1  single clock; all logic rising-edge
- `axis_areset`  in  1  synchronous, active-high reset
- `req0_valid` / `req1_valid`  in  1  request present; payload held stable until accepted
- `req0_wr` / `req1_wr`  in  1  1 = write, 0 = read
- `req0_addr` / `req1_addr`  in  ADDR_WIDTH  word address
- `req0_wdata` / `req1_wdata`  in  DATA_WIDTH  write data
- `req0_tstrb` / `req1_tstrb`  in  DATA_WIDTH/8  write byte strobes
- `req0_ready` / `req1_ready`  out  1  request accepted this cycle
- `rsp0_valid` / `rsp1_valid`  out  1  one-cycle completion pulse
- `rsp0_rdata` / `rsp1_rdata`  out  DATA_WIDTH  read data; 0 for writes and errors
- `rsp0_err` / `rsp1_err`  out  1  timeout flag, valid with rsp
- `s02_axis_wr_en`, `s02_axis_tvalid`, `s02_axis_tlast`  out  1  memory write controls
- `s02_axis_wr_addr`  out  ADDR_WIDTH; `s02_axis_wr_tdata`  out  DATA_WIDTH; `s02_axis_tstrb`  out  DATA_WIDTH/8
- `s02_axis_tready`  in  1  memory accepts write
- `m02_axis_rd_en`, `m02_axis_tready`  out  1  memory read controls
- `m02_axis_rd_addr`  out  ADDR_WIDTH
- `m02_axis_rd_tdata`  in  DATA_WIDTH; `m02_axis_tvalid`  in  1  read data valid

## Operation
- States: IDLE, WRITE, READ, RESP.
- **IDLE**
  - Grant is a combinational function of the requests and `last_grant`.
    - Only one `reqN_valid` high: that requester wins.
    - Both high: the requester other than `last_grant` wins.
    - Reset sets `last_grant` = 1, so req0 wins the first tie.
  - The winner's `reqN_ready` is 1 in the same cycle. Ready is only ever high in IDLE and to at most one requester.
  - On accept, latch id, wr, addr, wdata and tstrb, clear the timeout counter, and go to WRITE if wr=1, else READ.
- **WRITE**
  - Drive `s02_axis_wr_en` = `s02_axis_tvalid` = `s02_axis_tlast` = 1, with the latched addr, data and strobe.
  - On `s02_axis_tready` = 1: go to RESP with err=0.
- **READ**
  - Drive `m02_axis_rd_en` = `m02_axis_tready` = 1 and `m02_axis_rd_addr` = latched addr.
  - On `m02_axis_tvalid` = 1: capture `m02_axis_rd_tdata` and go to RESP with err=0.
- **Timeout**
  - The counter increments each cycle spent in WRITE or READ.
  - If the count reaches TIMEOUT-1 without completion, go to RESP with err=1 and rdata=0.
  - Completion in the same cycle as timeout takes precedence (err=0).
- **RESP**
  - Only the latched requester's `rspN_valid` = 1, for exactly one cycle, with its rdata/err.
  - Set `last_grant` to that id and return to IDLE.
- Memory-side outputs are Moore outputs of the state. All enables are 0 outside WRITE/READ. Address and data outputs hold their last latched value.
- `rspN_rdata` / `rspN_err` hold until the next response to that requester.
- A requester dropping valid before ready is legal; nothing is latched.
- Reset in any state:
  - Next cycle is IDLE.
  - All outputs 0, counter 0, `last_grant` = 1, latches 0.
  - The in-flight access is abandoned and no response is issued.

## Timing
- Accept at cycle T.
- Memory controls are asserted from T+1.
- With the memory responding at T+1, `rspN_valid` is at T+2 and the next accept is possible at T+3. The minimum transaction is 3 cycles.
- A memory stall of k cycles adds k cycles.
- Worst case is accept, then TIMEOUT cycles in WRITE/READ, then RESP: TIMEOUT+2 cycles.
- No pipelining: a new grant is never issued while a transaction is outstanding.

## Test plan
- Reset held 2 cycles, then released with no requests -> all outputs 0, state IDLE, no ready pulses for 10 cycles.
- req0 write addr 0x001, data 0x00000022, tstrb 0xF; memory tready=1 -> `req0_ready` at T, `s02_axis_wr_en`=1 with addr 0x001 at T+1, `rsp0_valid`=1 with err=0 at T+2.
- req1 read addr 0x001; memory returns tvalid with 0x00000022 after a 3-cycle stall -> `m02_axis_rd_en` high for 4 cycles, `rsp1_valid` with rdata 0x00000022, err=0.
- Both requesters continuously valid (req0 reads 0x010, req1 writes 0x020) for 4 transactions -> grants alternate 0,1,0,1; never two ready pulses in one cycle.
- Read where `m02_axis_tvalid` never asserts, TIMEOUT=16 -> `rsp0_valid` with err=1, rdata=0 exactly 17 cycles after accept, then IDLE.
- Reset asserted during READ stall -> next cycle IDLE, all enables 0, no `rspN_valid`; the following tie grants req0.
